// File: rtl/gap_pkg.sv
// Shared types and elaboration-time helpers for the global average pooling stage.
package gap_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        SCALE,
        OUTPUT
    } gap_state_e;

    // Rounded fixed-point reciprocal: round(2^bits / n).
    function automatic int calc_recip(input int n, input int bits);
        longint num;
        num = (longint'(1) << bits) + longint'(n / 2);
        return int'(num / longint'(n));
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (width - 1));
        if (value > maxV) begin
            return maxV;
        end else if (value < minV) begin
            return minV;
        end
        return value;
    endfunction

endpackage

// File: rtl/gap_scale_unit.sv
// One-channel scaler: multiply the frame sum by the reciprocal, round half up,
// shift back to the sample Q-format and clamp. Shared across channels by the top.
module gap_scale_unit
    import gap_pkg::*;
#(
    parameter int ACC_WIDTH  = 15,
    parameter int DATA_WIDTH = 8,
    parameter int RECIP_BITS = 16,
    parameter int RECIP      = 1337
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic signed [DATA_WIDTH-1:0] avg_o
);

    localparam int PROD_W = ACC_WIDTH + RECIP_BITS + 1;
    localparam logic signed [PROD_W-1:0] RECIP_C = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(longint'(1) << (RECIP_BITS - 1));

    logic signed [PROD_W-1:0] accExt;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    // Full-width signed product; the arithmetic shift floors, so adding half first rounds up.
    always_comb begin
        accExt  = PROD_W'(acc_i);
        prod    = accExt * RECIP_C + ROUND_C;
        shifted = prod >>> RECIP_BITS;
        avg_o   = DATA_WIDTH'(sat(64'(shifted), DATA_WIDTH));
    end

endmodule

// File: rtl/global_avg_pool.sv
// Streaming global average pool: sums every channel over a frame, then scales
// one channel per cycle through a shared multiplier and holds the vector until accepted.
module global_avg_pool
    import gap_pkg::*;
#(
    parameter int CHANNELS   = 16,
    parameter int IN_HEIGHT  = 7,
    parameter int IN_WIDTH   = 7,
    parameter int DATA_WIDTH = 8,
    parameter int RECIP_BITS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [0:CHANNELS-1][DATA_WIDTH-1:0]  in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [0:CHANNELS-1][DATA_WIDTH-1:0]  out_data,
    output logic                                 frame_err
);

    localparam int N         = IN_HEIGHT * IN_WIDTH;
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(N) + 1;
    localparam int RECIP     = calc_recip(N, RECIP_BITS);
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    gap_state_e state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc_d [CHANNELS];
    logic [CNT_W-1:0] pixCnt_q, pixCnt_d;
    logic [CH_W-1:0] chIdx_q, chIdx_d;
    logic [0:CHANNELS-1][DATA_WIDTH-1:0] outData_q, outData_d;
    logic frameErr_q, frameErr_d;

    logic beatFire;
    logic lastBeat;
    logic signed [DATA_WIDTH-1:0] scaleAvg;

    gap_scale_unit #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RECIP_BITS(RECIP_BITS),
        .RECIP     (RECIP)
    ) u_scale (
        .acc_i(acc_q[chIdx_q]),
        .avg_o(scaleAvg)
    );

    assign beatFire = in_valid && (state_q == ACCUM);
    assign lastBeat = (pixCnt_q == CNT_W'(N - 1));

    // Framing follows pix_cnt alone; in_last only feeds the sticky error flag.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pixCnt_d   = pixCnt_q;
        chIdx_d    = chIdx_q;
        outData_d  = outData_q;
        frameErr_d = frameErr_q;

        case (state_q)
            ACCUM: begin
                if (beatFire) begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        acc_d[ch] = acc_q[ch] + ACC_WIDTH'($signed(in_data[ch]));
                    end
                    if (in_last != lastBeat) begin
                        frameErr_d = 1'b1;
                    end
                    if (lastBeat) begin
                        pixCnt_d = '0;
                        chIdx_d  = '0;
                        state_d  = SCALE;
                    end else begin
                        pixCnt_d = pixCnt_q + CNT_W'(1);
                    end
                end
            end
            SCALE: begin
                outData_d[chIdx_q] = scaleAvg;
                if (chIdx_q == CH_W'(CHANNELS - 1)) begin
                    chIdx_d = '0;
                    state_d = OUTPUT;
                end else begin
                    chIdx_d = chIdx_q + CH_W'(1);
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        acc_d[ch] = '0;
                    end
                    pixCnt_d = '0;
                    state_d  = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch] <= '0;
            end
            pixCnt_q   <= '0;
            chIdx_q    <= '0;
            outData_q  <= '0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pixCnt_q   <= pixCnt_d;
            chIdx_q    <= chIdx_d;
            outData_q  <= outData_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign out_data  = outData_q;
    assign frame_err = frameErr_q;

endmodule
